// File: rtl/dbus_bridge.sv
`default_nettype none
// ============================================================================
// Module   : dbus_bridge
// Purpose  : Bridges the MM-stage data-memory access port of a pipelined CPU
//            onto an SRAM-like request/response bus. One transaction is in
//            flight at a time. The pipeline is stalled until the response
//            returns, and the load result is held while later stages stall.
// Ports    :
//   clk, rst_n          clock, synchronous active-low reset
//   dbus_en/we/addr/data   MM-stage request (level, held while stalled)
//   pipe_stall          later stages stalled; the MM result must be held
//   dbus_stall          bridge stalls the pipeline
//   dbus_rdata          raw aligned load word
//   data_req/wr/size/addr/wdata/wstrb   bus request side
//   data_addr_ok/data_data_ok/data_rdata bus handshake and response
//   dbus_ades           store address error (only with DBUS_ALIGN_CHK_EN)
// Config   : define DBUS_ALIGN_CHK_EN to enable store alignment checking.
//            Misaligned stores then complete without a bus access and raise
//            dbus_ades.
// Revision : 1.0 - initial release
// ============================================================================
module dbus_bridge (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dbus_en,
  input  logic [3:0]  dbus_we,
  input  logic [31:0] dbus_addr,
  input  logic [31:0] dbus_data,
  input  logic        pipe_stall,
  output logic        dbus_stall,
  output logic [31:0] dbus_rdata,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  output logic [3:0]  data_wstrb,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
`ifdef DBUS_ALIGN_CHK_EN
  ,
  output logic        dbus_ades
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic        r_wr;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [31:0] r_rdata;

  // Request decode. Byte-enable patterns other than the three store
  // encodings fall through to a plain word load.
  logic        w_is_sb;
  logic        w_is_sh;
  logic        w_is_sw;
  logic        w_is_store;
  logic [1:0]  w_size;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic [3:0]  w_wstrb;
  logic        w_misalign;
  logic        w_capture;

  assign w_is_sb    = (dbus_we == 4'b0001);
  assign w_is_sh    = (dbus_we == 4'b0011);
  assign w_is_sw    = (dbus_we == 4'b1111);
  assign w_is_store = w_is_sb | w_is_sh | w_is_sw;

  always_comb begin
    w_size  = 2'd2;
    w_wdata = dbus_data;
    if (w_is_sb) begin
      w_size  = 2'd0;
      w_wdata = {4{dbus_data[7:0]}};
    end else if (w_is_sh) begin
      w_size  = 2'd1;
      w_wdata = {2{dbus_data[15:0]}};
    end
  end

  // Loads always fetch the whole aligned word; stores keep the byte address
  // and move the strobe into the addressed lanes (bits shifted past lane 3
  // are dropped).
  assign w_addr  = w_is_store ? dbus_addr : {dbus_addr[31:2], 2'b00};
  assign w_wstrb = w_is_store ? (dbus_we << dbus_addr[1:0]) : 4'b0000;

`ifdef DBUS_ALIGN_CHK_EN
  logic r_ades;
  assign w_misalign = (w_is_sh & dbus_addr[0]) |
                      (w_is_sw & (dbus_addr[1:0] != 2'b00));
  assign dbus_ades  = r_ades & (r_state == S_DONE);
`else
  assign w_misalign = 1'b0;
`endif

  // The response for a read is taken only on the edge that moves the FSM
  // into DONE. A data_ok seen in IDLE or DONE is not ours and is ignored.
  assign w_capture = ~r_wr &
                     (((r_state == S_REQ) & data_addr_ok & data_data_ok) |
                      ((r_state == S_WAIT) & data_data_ok));

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (dbus_en) begin
          w_state_next = w_misalign ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (data_addr_ok) begin
          w_state_next = data_data_ok ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (data_data_ok) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (!pipe_stall) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_wr    <= 1'b0;
      r_size  <= 2'd0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_wstrb <= 4'd0;
      r_rdata <= 32'd0;
`ifdef DBUS_ALIGN_CHK_EN
      r_ades  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      if ((r_state == S_IDLE) && dbus_en) begin
        r_wr    <= w_is_store;
        r_size  <= w_size;
        r_addr  <= w_addr;
        r_wdata <= w_wdata;
        r_wstrb <= w_wstrb;
`ifdef DBUS_ALIGN_CHK_EN
        r_ades  <= w_misalign;
`endif
      end
      if (w_capture) begin
        r_rdata <= data_rdata;
      end
    end
  end

  assign data_req   = (r_state == S_REQ);
  assign data_wr    = r_wr;
  assign data_size  = r_size;
  assign data_addr  = r_addr;
  assign data_wdata = r_wdata;
  assign data_wstrb = r_wstrb;
  assign dbus_rdata = r_rdata;
  assign dbus_stall = dbus_en & (r_state != S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_dbus_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_dbus_bridge
// Purpose  : Directed self-checking bench for dbus_bridge. Each task drives
//            one scenario cycle by cycle and compares outputs against
//            hand-computed values.
// Config   : honours DBUS_ALIGN_CHK_EN to match the DUT build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dbus_bridge;

  logic        clk;
  logic        rst_n;
  logic        dbus_en;
  logic [3:0]  dbus_we;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_data;
  logic        pipe_stall;
  logic        dbus_stall;
  logic [31:0] dbus_rdata;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
`ifdef DBUS_ALIGN_CHK_EN
  logic        dbus_ades;
`endif

  int checks;
  int errors;

  dbus_bridge u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .dbus_en      (dbus_en),
    .dbus_we      (dbus_we),
    .dbus_addr    (dbus_addr),
    .dbus_data    (dbus_data),
    .pipe_stall   (pipe_stall),
    .dbus_stall   (dbus_stall),
    .dbus_rdata   (dbus_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_wstrb   (data_wstrb),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata)
`ifdef DBUS_ALIGN_CHK_EN
    ,
    .dbus_ades    (dbus_ades)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs for the new cycle
  // are driven here and outputs are checked 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; dbus_en = 1'b1;
    step(); step();
    #1;
    checks++; if (data_req !== 1'b0) begin errors++; $display("FAIL rst_req got %0b exp 0", data_req); end
    checks++; if (dbus_rdata !== 32'd0) begin errors++; $display("FAIL rst_rdata got %08h exp 00000000", dbus_rdata); end
    checks++; if (data_addr !== 32'd0) begin errors++; $display("FAIL rst_addr got %08h exp 00000000", data_addr); end
    checks++; if (dbus_stall !== 1'b1) begin errors++; $display("FAIL rst_stall_en got %0b exp 1", dbus_stall); end
    dbus_en = 1'b0;
    #1;
    checks++; if (dbus_stall !== 1'b0) begin errors++; $display("FAIL rst_stall_noen got %0b exp 0", dbus_stall); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_load();
    dbus_en = 1'b1; dbus_we = 4'b0000; dbus_addr = 32'h1000_0006; dbus_data = 32'h0;
    #1;
    checks++; if (dbus_stall !== 1'b1) begin errors++; $display("FAIL ld_stall_c0 got %0b exp 1", dbus_stall); end
    checks++; if (data_req !== 1'b0) begin errors++; $display("FAIL ld_req_c0 got %0b exp 0", data_req); end
    step();
    data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'hAABB_CCDD;
    #1;
    checks++; if (data_req !== 1'b1) begin errors++; $display("FAIL ld_req_c1 got %0b exp 1", data_req); end
    checks++; if (data_wr !== 1'b0) begin errors++; $display("FAIL ld_wr got %0b exp 0", data_wr); end
    checks++; if (data_addr !== 32'h1000_0004) begin errors++; $display("FAIL ld_addr got %08h exp 10000004", data_addr); end
    checks++; if (data_size !== 2'd2) begin errors++; $display("FAIL ld_size got %0d exp 2", data_size); end
    checks++; if (data_wstrb !== 4'b0000) begin errors++; $display("FAIL ld_wstrb got %04b exp 0000", data_wstrb); end
    checks++; if (dbus_stall !== 1'b1) begin errors++; $display("FAIL ld_stall_c1 got %0b exp 1", dbus_stall); end
    step();
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
    #1;
    checks++; if (dbus_stall !== 1'b0) begin errors++; $display("FAIL ld_stall_c2 got %0b exp 0", dbus_stall); end
    checks++; if (dbus_rdata !== 32'hAABB_CCDD) begin errors++; $display("FAIL ld_rdata got %08h exp AABBCCDD", dbus_rdata); end
    checks++; if (data_req !== 1'b0) begin errors++; $display("FAIL ld_req_c2 got %0b exp 0", data_req); end
    step();
    dbus_en = 1'b0;
  endtask

  task automatic test_sb();
    step();
    dbus_en = 1'b1; dbus_we = 4'b0001; dbus_addr = 32'h2000_0003; dbus_data = 32'h0000_0012;
    step();
    data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
    #1;
    checks++; if (data_req !== 1'b1) begin errors++; $display("FAIL sb_req got %0b exp 1", data_req); end
    checks++; if (data_wstrb !== 4'b1000) begin errors++; $display("FAIL sb_wstrb got %04b exp 1000", data_wstrb); end
    checks++; if (data_wdata !== 32'h1212_1212) begin errors++; $display("FAIL sb_wdata got %08h exp 12121212", data_wdata); end
    checks++; if (data_size !== 2'd0) begin errors++; $display("FAIL sb_size got %0d exp 0", data_size); end
    checks++; if (data_wr !== 1'b1) begin errors++; $display("FAIL sb_wr got %0b exp 1", data_wr); end
    checks++; if (data_addr !== 32'h2000_0003) begin errors++; $display("FAIL sb_addr got %08h exp 20000003", data_addr); end
    step();
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
    #1;
    checks++; if (dbus_stall !== 1'b0) begin errors++; $display("FAIL sb_stall got %0b exp 0", dbus_stall); end
    checks++; if (dbus_rdata !== 32'hAABB_CCDD) begin errors++; $display("FAIL sb_rdata_kept got %08h exp AABBCCDD", dbus_rdata); end
    step();
    dbus_en = 1'b0;
  endtask

  task automatic test_sh_wait();
    step();
    dbus_en = 1'b1; dbus_we = 4'b0011; dbus_addr = 32'h3000_0002; dbus_data = 32'h0000_BEEF;
    #1;
    checks++; if (dbus_stall !== 1'b1) begin errors++; $display("FAIL sh_stall_c0 got %0b exp 1", dbus_stall); end
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++; if (data_req !== 1'b1) begin errors++; $display("FAIL sh_req_c%0d got %0b exp 1", i, data_req); end
      checks++; if (data_wstrb !== 4'b1100) begin errors++; $display("FAIL sh_wstrb_c%0d got %04b exp 1100", i, data_wstrb); end
      checks++; if (data_wdata !== 32'hBEEF_BEEF) begin errors++; $display("FAIL sh_wdata_c%0d got %08h exp BEEFBEEF", i, data_wdata); end
      checks++; if (data_size !== 2'd1) begin errors++; $display("FAIL sh_size_c%0d got %0d exp 1", i, data_size); end
      checks++; if (data_addr !== 32'h3000_0002) begin errors++; $display("FAIL sh_addr_c%0d got %08h exp 30000002", i, data_addr); end
      checks++; if (dbus_stall !== 1'b1) begin errors++; $display("FAIL sh_stall_c%0d got %0b exp 1", i, dbus_stall); end
    end
    step();
    data_addr_ok = 1'b1;
    #1;
    checks++; if (data_req !== 1'b1) begin errors++; $display("FAIL sh_req_c4 got %0b exp 1", data_req); end
    step();
    data_addr_ok = 1'b0;
    #1;
    checks++; if (data_req !== 1'b0) begin errors++; $display("FAIL sh_req_wait got %0b exp 0", data_req); end
    checks++; if (dbus_stall !== 1'b1) begin errors++; $display("FAIL sh_stall_wait got %0b exp 1", dbus_stall); end
    step();
    data_data_ok = 1'b1;
    #1;
    checks++; if (dbus_stall !== 1'b1) begin errors++; $display("FAIL sh_stall_c6 got %0b exp 1", dbus_stall); end
    step();
    data_data_ok = 1'b0;
    #1;
    checks++; if (dbus_stall !== 1'b0) begin errors++; $display("FAIL sh_stall_done got %0b exp 0", dbus_stall); end
    checks++; if (dbus_rdata !== 32'hAABB_CCDD) begin errors++; $display("FAIL sh_rdata_kept got %08h exp AABBCCDD", dbus_rdata); end
    step();
    dbus_en = 1'b0;
  endtask

  task automatic test_pipe_stall();
    step();
    dbus_en = 1'b1; dbus_we = 4'b0000; dbus_addr = 32'h4000_0000; dbus_data = 32'h0;
    step();
    data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h1122_3344; pipe_stall = 1'b1;
    #1;
    checks++; if (data_req !== 1'b1) begin errors++; $display("FAIL ps_req got %0b exp 1", data_req); end
    for (int i = 0; i < 5; i++) begin
      step();
      data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h5500_0000 + i;
      #1;
      checks++; if (dbus_stall !== 1'b0) begin errors++; $display("FAIL ps_stall_%0d got %0b exp 0", i, dbus_stall); end
      checks++; if (dbus_rdata !== 32'h1122_3344) begin errors++; $display("FAIL ps_rdata_%0d got %08h exp 11223344", i, dbus_rdata); end
      checks++; if (data_req !== 1'b0) begin errors++; $display("FAIL ps_req_%0d got %0b exp 0", i, data_req); end
    end
    step();
    pipe_stall = 1'b0;
    #1;
    checks++; if (dbus_stall !== 1'b0) begin errors++; $display("FAIL ps_stall_rel got %0b exp 0", dbus_stall); end
    step();
    dbus_en = 1'b0;
    #1;
    checks++; if (data_req !== 1'b0) begin errors++; $display("FAIL ps_req_idle got %0b exp 0", data_req); end
    step();
    checks++; if (data_req !== 1'b0) begin errors++; $display("FAIL ps_req_idle2 got %0b exp 0", data_req); end
  endtask

  task automatic test_reset_wait();
    step();
    dbus_en = 1'b1; dbus_we = 4'b0000; dbus_addr = 32'h6000_0008;
    step();
    data_addr_ok = 1'b1; data_data_ok = 1'b0;
    #1;
    checks++; if (data_req !== 1'b1) begin errors++; $display("FAIL rw_req got %0b exp 1", data_req); end
    step();
    data_addr_ok = 1'b0;
    #1;
    checks++; if (data_req !== 1'b0) begin errors++; $display("FAIL rw_req_wait got %0b exp 0", data_req); end
    checks++; if (dbus_stall !== 1'b1) begin errors++; $display("FAIL rw_stall_wait got %0b exp 1", dbus_stall); end
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; dbus_en = 1'b0;
    #1;
    checks++; if (data_req !== 1'b0) begin errors++; $display("FAIL rw_req_after got %0b exp 0", data_req); end
    checks++; if (dbus_rdata !== 32'd0) begin errors++; $display("FAIL rw_rdata_after got %08h exp 00000000", dbus_rdata); end
    checks++; if (dbus_stall !== 1'b0) begin errors++; $display("FAIL rw_stall_after got %0b exp 0", dbus_stall); end
    dbus_en = 1'b1;
    #1;
    checks++; if (dbus_stall !== 1'b1) begin errors++; $display("FAIL rw_stall_idle_en got %0b exp 1", dbus_stall); end
    dbus_en = 1'b0;
  endtask

  task automatic test_misaligned_sw();
    step();
    dbus_en = 1'b1; dbus_we = 4'b1111; dbus_addr = 32'h5000_0001; dbus_data = 32'hCAFE_F00D;
    step();
`ifdef DBUS_ALIGN_CHK_EN
    checks++; if (data_req !== 1'b0) begin errors++; $display("FAIL ma_req got %0b exp 0", data_req); end
    checks++; if (dbus_ades !== 1'b1) begin errors++; $display("FAIL ma_ades got %0b exp 1", dbus_ades); end
    checks++; if (dbus_stall !== 1'b0) begin errors++; $display("FAIL ma_stall got %0b exp 0", dbus_stall); end
    step();
    dbus_en = 1'b0;
    #1;
    checks++; if (data_req !== 1'b0) begin errors++; $display("FAIL ma_req_idle got %0b exp 0", data_req); end
    checks++; if (dbus_ades !== 1'b0) begin errors++; $display("FAIL ma_ades_idle got %0b exp 0", dbus_ades); end
`else
    data_addr_ok = 1'b1; data_data_ok = 1'b1;
    #1;
    checks++; if (data_req !== 1'b1) begin errors++; $display("FAIL ma_req got %0b exp 1", data_req); end
    checks++; if (data_addr !== 32'h5000_0001) begin errors++; $display("FAIL ma_addr got %08h exp 50000001", data_addr); end
    checks++; if (data_wstrb !== 4'b1110) begin errors++; $display("FAIL ma_wstrb got %04b exp 1110", data_wstrb); end
    checks++; if (data_size !== 2'd2) begin errors++; $display("FAIL ma_size got %0d exp 2", data_size); end
    checks++; if (data_wdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL ma_wdata got %08h exp CAFEF00D", data_wdata); end
    step();
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
    #1;
    checks++; if (dbus_stall !== 1'b0) begin errors++; $display("FAIL ma_stall got %0b exp 0", dbus_stall); end
    step();
    dbus_en = 1'b0;
`endif
  endtask

  task automatic test_invalid_we();
    step();
    dbus_en = 1'b1; dbus_we = 4'b0101; dbus_addr = 32'h7000_0007; dbus_data = 32'h1234_5678;
    step();
    data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h0BAD_F00D;
    #1;
    checks++; if (data_wr !== 1'b0) begin errors++; $display("FAIL iw_wr got %0b exp 0", data_wr); end
    checks++; if (data_addr !== 32'h7000_0004) begin errors++; $display("FAIL iw_addr got %08h exp 70000004", data_addr); end
    checks++; if (data_size !== 2'd2) begin errors++; $display("FAIL iw_size got %0d exp 2", data_size); end
    checks++; if (data_wstrb !== 4'b0000) begin errors++; $display("FAIL iw_wstrb got %04b exp 0000", data_wstrb); end
    step();
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
    #1;
    checks++; if (dbus_rdata !== 32'h0BAD_F00D) begin errors++; $display("FAIL iw_rdata got %08h exp 0BADF00D", dbus_rdata); end
    step();
    dbus_en = 1'b0;
  endtask

  task automatic test_spurious_ok();
    step();
    data_data_ok = 1'b1; data_addr_ok = 1'b1; data_rdata = 32'h9999_9999;
    step(); step();
    data_data_ok = 1'b0; data_addr_ok = 1'b0;
    #1;
    checks++; if (dbus_rdata !== 32'h0BAD_F00D) begin errors++; $display("FAIL sp_rdata got %08h exp 0BADF00D", dbus_rdata); end
    checks++; if (data_req !== 1'b0) begin errors++; $display("FAIL sp_req got %0b exp 0", data_req); end
  endtask

  task automatic test_back_to_back();
    step();
    dbus_en = 1'b1; dbus_we = 4'b0000; dbus_addr = 32'h8000_0000;
    step();
    data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h0101_0101;
    step();
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
    #1;
    checks++; if (dbus_rdata !== 32'h0101_0101) begin errors++; $display("FAIL bb_rdata1 got %08h exp 01010101", dbus_rdata); end
    step();
    dbus_addr = 32'h8000_0010;
    #1;
    checks++; if (dbus_stall !== 1'b1) begin errors++; $display("FAIL bb_stall_idle got %0b exp 1", dbus_stall); end
    checks++; if (data_req !== 1'b0) begin errors++; $display("FAIL bb_req_idle got %0b exp 0", data_req); end
    step();
    data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h0202_0202;
    #1;
    checks++; if (data_req !== 1'b1) begin errors++; $display("FAIL bb_req2 got %0b exp 1", data_req); end
    checks++; if (data_addr !== 32'h8000_0010) begin errors++; $display("FAIL bb_addr2 got %08h exp 80000010", data_addr); end
    step();
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
    #1;
    checks++; if (dbus_stall !== 1'b0) begin errors++; $display("FAIL bb_stall2 got %0b exp 0", dbus_stall); end
    checks++; if (dbus_rdata !== 32'h0202_0202) begin errors++; $display("FAIL bb_rdata2 got %08h exp 02020202", dbus_rdata); end
    step();
    dbus_en = 1'b0;
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    dbus_en      = 1'b0;
    dbus_we      = 4'b0000;
    dbus_addr    = 32'h0;
    dbus_data    = 32'h0;
    pipe_stall   = 1'b0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata   = 32'h0;

    test_reset();
    test_load();
    test_sb();
    test_sh_wait();
    test_pipe_stall();
    test_reset_wait();
    test_misaligned_sw();
    test_invalid_we();
    test_spurious_ok();
    test_back_to_back();

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
